hazard_unit_param: RTL and testbench

Parametrised hazard detection and stall/flush controller for the five-stage MIPS pipeline. It sits beside the ID stage. It keeps a shift-register scoreboard of in-flight register writers (EX onward) and compares them against the sources of the instruction in ID. From that it drives PC/IF-ID hold, ID/EX bubble insertion and IF/ID flush on taken branches. It supports forwarding and non-forwarding pipelines, configurable depth and load latency, and a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_scoreboard.sv | 34 +++
 rtl/hazard_unit_param.sv | 92 +++++++++
 tb/tb_hazard_unit_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard unit
package hazard_pkg;

    localparam int DEF_REG_W    = 5;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_FORWARD  = 1;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_CNT_W    = 32;

    localparam int REG_ZERO = 0;

    // Field order here is also the bit order of each slot in the flat entry vector.
    typedef struct packed {
        logic                 valid;
        logic [DEF_REG_W-1:0] rd;
        logic                 is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift register of in-flight register writers
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_valid,
    input  logic [REG_W-1:0]              push_rd,
    input  logic                          push_load,
    output logic [DEPTH*(REG_W+2)-1:0]    entries
);

    localparam int ENTRY_W = REG_W + 2;

    logic [DEPTH-1:0][ENTRY_W-1:0] sb;

    // Slot 0 is EX; later stages never stall, so every slot advances each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb[0] <= {push_valid, push_rd, push_load};
            for (int k = 1; k < DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    assign entries = sb;

endmodule

// File: rtl/hazard_unit_param.sv
// rtl/hazard_unit_param.sv - stall/bubble/flush controller beside the ID stage
module hazard_unit_param
    import hazard_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int FORWARD  = DEF_FORWARD,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             ID_Valid,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_RsUsed,
    input  logic             ID_RtUsed,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             EX_BranchTaken,
    output logic             Stall,
    output logic             BubbleEX,
    output logic             FlushIFID,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int ENTRY_W = REG_W + 2;

    logic [DEPTH*ENTRY_W-1:0] entries;
    logic                     push_valid;
    logic                     haz_rs;
    logic                     haz_rt;

    // Scan oldest to youngest so the youngest matching writer is the one that sticks.
    function automatic logic src_hazard(
        input logic [REG_W-1:0]         src,
        input logic                     used,
        input logic [DEPTH*ENTRY_W-1:0] sb
    );
        logic               found;
        logic               hit_load;
        int                 hit_k;
        logic [ENTRY_W-1:0] e;
        found    = 1'b0;
        hit_load = 1'b0;
        hit_k    = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            e = sb[k*ENTRY_W +: ENTRY_W];
            if (used && (src != REG_W'(REG_ZERO)) && e[ENTRY_W-1] && (e[REG_W:1] == src)) begin
                found    = 1'b1;
                hit_load = e[0];
                hit_k    = k;
            end
        end
        if (FORWARD == 0) begin
            return found;
        end
        return found && hit_load && (hit_k < LOAD_LAT);
    endfunction

    assign haz_rs = src_hazard(ID_Rs, ID_RsUsed, entries);
    assign haz_rt = src_hazard(ID_Rt, ID_RtUsed, entries);

    // A taken branch wins: the would-be stalled instruction is on the wrong path.
    assign Stall     = ID_Valid & (haz_rs | haz_rt) & ~EX_BranchTaken;
    assign FlushIFID = EX_BranchTaken;
    assign BubbleEX  = Stall | EX_BranchTaken;

    assign push_valid = ID_Valid & ID_RegWrite & (ID_Rd != REG_W'(REG_ZERO)) & ~BubbleEX;

    hazard_scoreboard #(
        .REG_W (REG_W),
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .push_valid (push_valid),
        .push_rd    (ID_Rd),
        .push_load  (ID_MemRead),
        .entries    (entries)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCycles <= '0;
        end else if (Stall && (StallCycles != {CNT_W{1'b1}})) begin
            StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_param.sv
// tb/tb_hazard_unit_param.sv - directed self-checking bench for hazard_unit_param
module tb_hazard_unit_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used;
    logic       id_reg_write, id_mem_read;
    logic       ex_branch_taken;

    logic        stall_f, bubble_f, flush_f;
    logic [31:0] cnt_f;
    logic        stall_n, bubble_n, flush_n;
    logic [1:0]  cnt_n;
    logic        stall_l, bubble_l, flush_l;
    logic [31:0] cnt_l;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_unit_param u_fwd (
        .Clk(clk), .Rst_n(rst_n), .ID_Valid(id_valid), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_RsUsed(id_rs_used), .ID_RtUsed(id_rt_used), .ID_Rd(id_rd),
        .ID_RegWrite(id_reg_write), .ID_MemRead(id_mem_read), .EX_BranchTaken(ex_branch_taken),
        .Stall(stall_f), .BubbleEX(bubble_f), .FlushIFID(flush_f), .StallCycles(cnt_f)
    );

    hazard_unit_param #(.FORWARD(0), .CNT_W(2)) u_nofwd (
        .Clk(clk), .Rst_n(rst_n), .ID_Valid(id_valid), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_RsUsed(id_rs_used), .ID_RtUsed(id_rt_used), .ID_Rd(id_rd),
        .ID_RegWrite(id_reg_write), .ID_MemRead(id_mem_read), .EX_BranchTaken(ex_branch_taken),
        .Stall(stall_n), .BubbleEX(bubble_n), .FlushIFID(flush_n), .StallCycles(cnt_n)
    );

    hazard_unit_param #(.LOAD_LAT(3)) u_lat3 (
        .Clk(clk), .Rst_n(rst_n), .ID_Valid(id_valid), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_RsUsed(id_rs_used), .ID_RtUsed(id_rt_used), .ID_Rd(id_rd),
        .ID_RegWrite(id_reg_write), .ID_MemRead(id_mem_read), .EX_BranchTaken(ex_branch_taken),
        .Stall(stall_l), .BubbleEX(bubble_l), .FlushIFID(flush_l), .StallCycles(cnt_l)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic rsu, input logic rtu, input logic [4:0] rd,
                             input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rs_used   = rsu;
        id_rt_used   = rtu;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_stall", stall_f, 0);
        chk("reset_bubble", bubble_f, 0);
        chk("reset_flush", flush_f, 0);
        chk("reset_cnt_f", cnt_f, 0);
        chk("reset_cnt_n", cnt_n, 0);
        rst_n = 1'b1;

        // load-use: lw $8 ; add $9,$8,$10
        set_instr(1, 29, 8, 1, 0, 8, 1, 1); #1;
        chk("lu_lw_stall_f", stall_f, 0);
        tick();
        set_instr(1, 8, 10, 1, 1, 9, 1, 0); #1;
        chk("lu_c1_stall_f", stall_f, 1);
        chk("lu_c1_bubble_f", bubble_f, 1);
        chk("lu_c1_flush_f", flush_f, 0);
        chk("lu_c1_stall_n", stall_n, 1);
        chk("lu_c1_stall_l", stall_l, 1);
        tick();
        chk("lu_c2_stall_f", stall_f, 0);
        chk("lu_c2_stall_n", stall_n, 1);
        chk("lu_c2_stall_l", stall_l, 1);
        chk("lu_c2_cnt_f", cnt_f, 1);
        tick();
        chk("lu_c3_stall_f", stall_f, 0);
        chk("lu_c3_stall_n", stall_n, 1);
        chk("lu_c3_stall_l", stall_l, 1);
        tick();
        chk("lu_c4_stall_n", stall_n, 0);
        chk("lu_c4_stall_l", stall_l, 0);
        chk("lu_cnt_n", cnt_n, 3);
        chk("lu_cnt_l", cnt_l, 3);
        chk("lu_cnt_f", cnt_f, 1);
        tick();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();
        chk("rst_cnt_f", cnt_f, 0);

        // ALU-use: add $8 ; sub $9,$8,$8
        set_instr(1, 1, 2, 1, 1, 8, 1, 0); #1;
        chk("alu_add_stall_f", stall_f, 0);
        tick();
        set_instr(1, 8, 8, 1, 1, 9, 1, 0); #1;
        chk("alu_c1_stall_f", stall_f, 0);
        chk("alu_c1_stall_n", stall_n, 1);
        tick();
        chk("alu_c2_stall_f", stall_f, 0);
        chk("alu_c2_stall_n", stall_n, 1);
        tick();
        chk("alu_c3_stall_n", stall_n, 1);
        tick();
        chk("alu_c4_stall_n", stall_n, 0);
        chk("alu_cnt_n", cnt_n, 3);
        chk("alu_cnt_f", cnt_f, 0);
        tick();

        // no-forward gap: add $8 ; or $11 ; and $12,$8,$0 (counter already saturated)
        set_instr(1, 1, 2, 1, 1, 8, 1, 0); #1;
        chk("gap_add_stall_n", stall_n, 0);
        tick();
        set_instr(1, 3, 4, 1, 1, 11, 1, 0); #1;
        chk("gap_or_stall_n", stall_n, 0);
        tick();
        set_instr(1, 8, 0, 1, 1, 12, 1, 0); #1;
        chk("gap_c1_stall_n", stall_n, 1);
        chk("gap_c1_stall_f", stall_f, 0);
        tick();
        chk("gap_c2_stall_n", stall_n, 1);
        tick();
        chk("gap_c3_stall_n", stall_n, 0);
        chk("gap_cnt_sat_n", cnt_n, 3);
        tick();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();

        // youngest wins: lw $8 ; nop ; add $8 ; sub $1,$8,$2
        set_instr(1, 29, 8, 1, 0, 8, 1, 1); tick();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_instr(1, 1, 2, 1, 1, 8, 1, 0); tick();
        set_instr(1, 8, 2, 1, 1, 1, 1, 0); #1;
        chk("yw_stall_f", stall_f, 0);
        chk("yw_stall_l", stall_l, 0);
        chk("yw_stall_n", stall_n, 1);
        tick();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();

        // $0 and unused sources
        set_instr(1, 29, 0, 1, 0, 0, 1, 1); tick();
        set_instr(1, 0, 0, 1, 1, 1, 1, 0); #1;
        chk("zero_stall_f", stall_f, 0);
        chk("zero_stall_n", stall_n, 0);
        tick();
        set_instr(1, 29, 8, 1, 0, 8, 1, 1); tick();
        set_instr(1, 8, 8, 0, 0, 0, 0, 0); #1;
        chk("unused_stall_f", stall_f, 0);
        chk("unused_stall_n", stall_n, 0);
        chk("unused_stall_l", stall_l, 0);
        tick();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();

        // branch during load-use, then asynchronous reset mid-stall
        set_instr(1, 29, 8, 1, 0, 8, 1, 1); tick();
        set_instr(1, 8, 10, 1, 1, 9, 1, 0);
        ex_branch_taken = 1'b1; #1;
        chk("br_stall_f", stall_f, 0);
        chk("br_flush_f", flush_f, 1);
        chk("br_bubble_f", bubble_f, 1);
        chk("br_stall_n", stall_n, 0);
        tick();
        ex_branch_taken = 1'b0;
        set_instr(1, 29, 8, 1, 0, 8, 1, 1); #1;
        chk("br_cnt_f", cnt_f, 0);
        chk("br_flush_off_f", flush_f, 0);
        tick();
        set_instr(1, 8, 10, 1, 1, 9, 1, 0); #1;
        chk("rs_c1_stall_f", stall_f, 1);
        chk("rs_c1_stall_n", stall_n, 1);
        tick();
        chk("rs_c2_stall_n", stall_n, 1);
        chk("rs_c2_cnt_n", cnt_n, 1);
        rst_n = 1'b0; #1;
        chk("rs_async_stall_n", stall_n, 0);
        chk("rs_async_bubble_n", bubble_n, 0);
        chk("rs_async_cnt_n", cnt_n, 0);
        chk("rs_async_cnt_f", cnt_f, 0);
        chk("rs_async_cnt_l", cnt_l, 0);
        tick();
        rst_n = 1'b1; #1;
        chk("rs_post_stall_n", stall_n, 0);
        chk("rs_post_stall_l", stall_l, 0);
        chk("rs_post_stall_f", stall_f, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
